// File: rtl/riscv_multicycle_core.sv
// Multicycle RV32I-subset core; FETCH/DECODE/EXEC/MEM/WB over one shared req/ready memory port.
// 2-5 cycles per instruction at zero wait; mem_ready low holds FETCH/MEM with mem_* outputs stable.
module riscv_multicycle_core #(
    parameter int          NREGS     = 32,
    parameter int          ADDR_W    = 10,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] HALT_WORD = 32'h1111_1111
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  clock_count,
    input  logic [4:0]        dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int PCW = ADDR_W + 2;
    localparam int RIW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [PCW-1:0] FOUR = PCW'(4);

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BR  = 7'h63;
    localparam logic [6:0] OP_LUI = 7'h37;
    localparam logic [6:0] OP_JAL = 7'h6F;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            state, state_nxt;
    logic [PCW-1:0]    pc, target;
    logic [31:0]       ir, ra, rb, imm, alu_out, mdr;
    logic [ADDR_W-1:0] mar;
    logic [31:0]       regs [NREGS];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_sel, alu_b, alu_res;
    logic [4:0]  shamt;
    logic [PCW-1:0] ea;
    logic        dec_ok, use_rd, use_rs1, use_rs2, dec_illegal;
    logic        br_taken, set_illegal;

    function automatic logic reg_bad(input logic [4:0] idx);
        return {1'b0, idx} >= 6'(NREGS);
    endfunction

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    // Decode: legality, register-field usage and immediate format
    always_comb begin
        dec_ok  = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        imm_sel = {{20{ir[31]}}, ir[31:20]};
        case (opcode)
            OP_R: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_ok = (funct7 == 7'h00) ||
                         (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
            end
            OP_I: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                if (funct3 == 3'd1)      dec_ok = (funct7 == 7'h00);
                else if (funct3 == 3'd5) dec_ok = (funct7 == 7'h00 || funct7 == 7'h20);
                else                     dec_ok = 1'b1;
            end
            OP_LW: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                dec_ok = (funct3 == 3'd2);
            end
            OP_SW: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_ok  = (funct3 == 3'd2);
                imm_sel = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            OP_BR: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_ok  = (funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd4 || funct3 == 3'd5);
                imm_sel = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OP_LUI: begin
                use_rd  = 1'b1;
                dec_ok  = 1'b1;
                imm_sel = {ir[31:12], 12'b0};
            end
            OP_JAL: begin
                use_rd  = 1'b1;
                dec_ok  = 1'b1;
                imm_sel = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            default: dec_ok = 1'b0;
        endcase
        dec_illegal = !dec_ok || (use_rd && reg_bad(rd)) ||
                      (use_rs1 && reg_bad(rs1)) || (use_rs2 && reg_bad(rs2));
    end

    // ALU, branch compare and effective address, all from the latched operands
    always_comb begin
        alu_b   = (opcode == OP_R) ? rb : imm;
        shamt   = alu_b[4:0];
        alu_res = '0;
        case (funct3)
            3'd0: alu_res = (opcode == OP_R && funct7[5]) ? ra - alu_b : ra + alu_b;
            3'd1: alu_res = ra << shamt;
            3'd2: alu_res = {31'b0, $signed(ra) < $signed(alu_b)};
            3'd3: alu_res = {31'b0, ra < alu_b};
            3'd4: alu_res = ra ^ alu_b;
            3'd5: alu_res = funct7[5] ? 32'($signed(ra) >>> shamt) : ra >> shamt;
            3'd6: alu_res = ra | alu_b;
            3'd7: alu_res = ra & alu_b;
            default: alu_res = '0;
        endcase
        case (funct3)
            3'd0:    br_taken = (ra == rb);
            3'd1:    br_taken = (ra != rb);
            3'd4:    br_taken = ($signed(ra) < $signed(rb));
            3'd5:    br_taken = ($signed(ra) >= $signed(rb));
            default: br_taken = 1'b0;
        endcase
        ea = ra[PCW-1:0] + imm[PCW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        set_illegal = 1'b0;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (ir == HALT_WORD) begin
                    state_nxt = S_HALT;
                end else if (dec_illegal) begin
                    state_nxt   = S_HALT;
                    set_illegal = 1'b1;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_LW, OP_SW: begin
                        set_illegal = (ea[1:0] != 2'b00);
                        state_nxt   = set_illegal ? S_HALT : S_MEM;
                    end
                    OP_BR: begin
                        set_illegal = br_taken && (target[1:0] != 2'b00);
                        state_nxt   = set_illegal ? S_HALT : S_FETCH;
                    end
                    OP_JAL: begin
                        set_illegal = (target[1:0] != 2'b00);
                        state_nxt   = set_illegal ? S_HALT : S_FETCH;
                    end
                    default: state_nxt = S_WB;
                endcase
            end
            S_MEM:   if (mem_ready) state_nxt = (opcode == OP_SW) ? S_FETCH : S_WB;
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    // Reset gates the request combinationally so it drops mid-transaction
    assign mem_req   = (state == S_FETCH || state == S_MEM) && !reset;
    assign mem_we    = (state == S_MEM) && (opcode == OP_SW) && !reset;
    assign mem_addr  = (state == S_MEM) ? mar : pc[PCW-1:2];
    assign mem_wdata = rb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            ir          <= '0;
            ra          <= '0;
            rb          <= '0;
            imm         <= '0;
            target      <= '0;
            alu_out     <= '0;
            mdr         <= '0;
            mar         <= '0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            clock_count <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (!done && clock_count != '1) clock_count <= clock_count + 1'b1;
            if (state_nxt == S_HALT) done <= 1'b1;
            if (set_illegal) illegal <= 1'b1;
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + FOUR;
                    end
                end
                S_DECODE: begin
                    ra     <= regs[rs1[RIW-1:0]];
                    rb     <= regs[rs2[RIW-1:0]];
                    imm    <= imm_sel;
                    target <= pc - FOUR + imm_sel[PCW-1:0];
                end
                S_EXEC: begin
                    alu_out <= (opcode == OP_LUI) ? imm : alu_res;
                    mar     <= ea[PCW-1:2];
                    if (state_nxt == S_FETCH && (opcode == OP_JAL || br_taken)) begin
                        pc <= target;
                        if (opcode == OP_JAL && rd != 5'd0) regs[rd[RIW-1:0]] <= 32'(pc);
                    end
                end
                S_MEM: begin
                    if (mem_ready) mdr <= mem_rdata;
                end
                S_WB: begin
                    if (rd != 5'd0) regs[rd[RIW-1:0]] <= (opcode == OP_LW) ? mdr : alu_out;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dbg_data = '0;
        if (dbg_addr != 5'd0 && !reg_bad(dbg_addr)) dbg_data = regs[dbg_addr[RIW-1:0]];
    end

endmodule

// File: doc/riscv_multicycle_core.md
Name: riscv_multicycle_core

Overview:
Parametrised multicycle RV32I-subset core that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. It is the successor to the fixed-function multicycle CPU used for matrix-vector test programs. Instruction/data memory is external and shared behind a single req/ready handshake, so wait states are supported. The core adds branches, jal, lui, full ALU ops, trap detection, a configurable register file and a debug read port.

Parameters:
NREGS, 32, architectural register count: 32 (RV32I) or 16 (RV32E-style); x0 hardwired to zero
ADDR_W, 10, memory word-address width; byte address = {mem_addr, 2'b00}
CNT_W, 16, width of clock_count
HALT_WORD, 32'h1111_1111, instruction encoding that ends the program

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_req  out  1  memory transaction request, held until accepted
mem_we  out  1  1 = write (sw), 0 = read (fetch/lw)
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  store data
mem_rdata  in  32  read data, valid in the cycle mem_req && mem_ready
mem_ready  in  1  memory completes the transaction this cycle
done  out  1  program finished (halt or trap), sticky
illegal  out  1  trap cause flag, sticky
clock_count  out  CNT_W  cycles elapsed from reset release until done
dbg_addr  in  5  register index for the debug read
dbg_data  out  32  combinational read of Regs[dbg_addr]; 0 if index is 0 or >= NREGS

Behaviour:
- Reset (async) forces: PC=0, all registers=0, state=FETCH, done=0, illegal=0, clock_count=0, mem_req=0, mem_we=0. mem_req drops immediately, even mid-transaction.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- mem_req is a Moore output: high in FETCH, and in MEM for lw/sw. mem_addr, mem_we and mem_wdata stay stable while mem_req is high.
- A state completes on the edge where mem_req && mem_ready; otherwise the state repeats.
- FETCH: IR<=mem_rdata; PC<=PC+4 -> DECODE.
- DECODE:
  - If IR==HALT_WORD -> HALT.
  - Otherwise read rs1/rs2, compute the sign-extended immediate (I/S/B/U/J formats), latch PC-4+immB/immJ as the target -> EXEC.
  - Unsupported opcode/funct, or a register index >= NREGS -> HALT with illegal=1.
- EXEC:
  - R ops: add, sub, sll, slt, sltu, xor, srl, sra, or, and. These are bitwise, not logical.
  - I ops: addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - Shift amount is the low 5 bits. slt/blt are signed; sltu is unsigned.
  - ALU ops and lui -> WB. lw/sw compute rs1+imm -> MEM.
  - beq/bne/blt/bge: if taken PC<=target; -> FETCH.
  - jal: rd<=PC, PC<=target -> FETCH.
  - Taken target with bits[1:0]!=0 -> HALT, illegal=1.
  - Effective address with bits[1:0]!=0 -> HALT, illegal=1.
- MEM: sw -> FETCH when accepted; lw captures MDR -> WB.
- WB: Regs[rd]<=ALUOut or MDR -> FETCH.
- Writes to x0 are discarded.
- Latency with zero-wait memory: ALU/lui 4 cycles, lw 5, sw 4, branch/jal 3, halt 2 (FETCH+DECODE). Each wait cycle adds 1.
- HALT: done=1 from the edge entering HALT; no further memory requests; state held until reset.
- clock_count: increments every cycle while done==0 and saturates at all-ones; frozen once done=1.
- Arithmetic wraps modulo 2^32. PC wraps past 2^(ADDR_W+2).

Test Plan:
1. addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; HALT_WORD, zero-wait memory -> dbg x3=2, x2=0xFFFFFFFD, done rises at cycle 14, clock_count=14.
2. sw x1,8(x0) then lw x4,8(x0), x1=0xDEADBEEF, mem_ready held low 3 cycles per access -> mem_addr/mem_we stable during waits, x4=0xDEADBEEF, each access 3 cycles longer.
3. Loop: addi x1,x1,1; bne x1,x2,-4 with x2=10 -> exits with x1=10; a not-taken branch falls through to PC+4.
4. x1=-8: srai x5,x1,1 -> 0xFFFFFFFC; srli -> 0x7FFFFFFC; slt(-1,1)=1; sltu(-1,1)=0; ori/andi produce bitwise results; addi x0,x0,7 leaves x0=0.
5. Instruction 0x0000007F, or x20 referenced with NREGS=16 -> illegal=1, done=1, no register changes, mem_req stays 0 afterwards.
6. reset asserted during a stalled lw (mem_req=1) -> mem_req=0 immediately, PC=0, registers cleared; after release the first fetch is at address 0.
